main_control_fsm: RTL and testbench

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

---
 rtl/main_control_fsm.sv | 172 +++++++++++++++++
 tb/tb_main_control_fsm.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm
// Description : Multi-cycle processor main control FSM. Sequences fetch,
//               decode, memory, ALU and branch steps from the opcode and
//               the memory handshake, and counts retired instructions.
//               Optional JAL support is enabled by defining the macro
//               MAIN_CONTROL_JAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module main_control_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic        branch,
    output logic        illegal,
    output logic [1:0]  alusrc_a,
    output logic [1:0]  alusrc_b,
    output logic [1:0]  aluop,
    output logic [1:0]  result_src,
    output logic [3:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
`ifdef MAIN_CONTROL_JAL_EN
    localparam logic [6:0] c_op_jal    = 7'b1101111;
`endif

    // Control word layout:
    // {pc_write, ir_write, mem_req, mem_we, iord, reg_write, branch, illegal,
    //  alusrc_a[1:0], alusrc_b[1:0], aluop[1:0], result_src[1:0]}
    // FETCH pc_write/ir_write are left 0 here; they follow mem_ready live.
    function automatic logic [15:0] ctrl_for(input state_t s);
        logic [15:0] c;
        c = 16'h0000;
        case (s)
            S_FETCH:    c = {8'b0010_0000, 8'b00_10_00_10};
            S_DECODE:   c = {8'b0000_0000, 8'b01_01_00_00};
            S_MEMADR:   c = {8'b0000_0000, 8'b10_01_00_00};
            S_MEMREAD:  c = {8'b0010_1000, 8'b00_00_00_00};
            S_MEMWB:    c = {8'b0000_0100, 8'b00_00_00_01};
            S_MEMWRITE: c = {8'b0011_1000, 8'b00_00_00_00};
            S_EXECUTER: c = {8'b0000_0000, 8'b10_00_10_00};
            S_EXECUTEI: c = {8'b0000_0000, 8'b10_01_10_00};
            S_ALUWB:    c = {8'b0000_0100, 8'b00_00_00_00};
            S_BEQ:      c = {8'b0000_0010, 8'b10_00_01_00};
`ifdef MAIN_CONTROL_JAL_EN
            S_JAL:      c = {8'b1000_0000, 8'b01_10_00_00};
`endif
            S_TRAP:     c = {8'b0000_0001, 8'b00_00_00_00};
            default:    c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] instret_q, instret_d;
    logic [15:0] ctrl_q, ctrl_d;
    logic        retire;
    logic        fetch_ack;

    // Next-state selection and retirement detection
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_op_load,
                    c_op_store:  state_d = S_MEMADR;
                    c_op_rtype:  state_d = S_EXECUTER;
                    c_op_itype:  state_d = S_EXECUTEI;
                    c_op_branch: state_d = S_BEQ;
`ifdef MAIN_CONTROL_JAL_EN
                    c_op_jal:    state_d = S_JAL;
`endif
                    default:     state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_BEQ: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef MAIN_CONTROL_JAL_EN
            S_JAL:      state_d = S_ALUWB;
`endif
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        instret_d = instret_q + {31'd0, retire};
        ctrl_d    = ctrl_for(state_d);
    end

    // State, retired count and control word registers; reset overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
            ctrl_q    <= ctrl_for(S_FETCH);
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Instruction-register and PC writes in FETCH track the live handshake
    assign fetch_ack  = (state_q == S_FETCH) && mem_ready;

    assign pc_write   = ctrl_q[15] | fetch_ack;
    assign ir_write   = ctrl_q[14] | fetch_ack;
    assign mem_req    = ctrl_q[13];
    assign mem_we     = ctrl_q[12];
    assign iord       = ctrl_q[11];
    assign reg_write  = ctrl_q[10];
    assign branch     = ctrl_q[9];
    assign illegal    = ctrl_q[8];
    assign alusrc_a   = ctrl_q[7:6];
    assign alusrc_b   = ctrl_q[5:4];
    assign aluop      = ctrl_q[3:2];
    assign result_src = ctrl_q[1:0];
    assign state      = state_q;
    assign instret    = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_control_fsm
// Description : Scoreboard bench for main_control_fsm. Instructions are
//               expanded into their expected per-cycle state/control/count
//               sequence; a monitor compares every cycle against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_req, mem_we, iord, reg_write, branch, illegal;
    logic [1:0]  alusrc_a, alusrc_b, aluop, result_src;
    logic [3:0]  state;
    logic [31:0] instret;

    main_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .reg_write  (reg_write),
        .branch     (branch),
        .illegal    (illegal),
        .alusrc_a   (alusrc_a),
        .alusrc_b   (alusrc_b),
        .aluop      (aluop),
        .result_src (result_src),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_instret = 32'd0;
    bit          aborted;
    bit          force_pending = 1'b0;
    int          abort_at;
    int          cyc_idx;
    logic [6:0]  cur_op;

    // Expected control word per state, straight from the output table.
    // Order: {pc_write, ir_write, mem_req, mem_we, iord, reg_write, branch,
    //         illegal, a, b, aluop, result_src}
    function automatic logic [15:0] ctl_of(input int s, input logic rdy);
        logic [7:0] f;
        logic [7:0] m;
        f = 8'h00;
        m = 8'h00;
        case (s)
            0:  begin f = {rdy, rdy, 6'b100000}; m = {2'd0, 2'd2, 2'd0, 2'd2}; end
            1:  m = {2'd1, 2'd1, 2'd0, 2'd0};
            2:  m = {2'd2, 2'd1, 2'd0, 2'd0};
            3:  f = 8'b0010_1000;
            4:  begin f = 8'b0000_0100; m = {2'd0, 2'd0, 2'd0, 2'd1}; end
            5:  f = 8'b0011_1000;
            6:  m = {2'd2, 2'd0, 2'd2, 2'd0};
            7:  f = 8'b0000_0100;
            8:  m = {2'd2, 2'd1, 2'd2, 2'd0};
            9:  begin f = 8'b0000_0010; m = {2'd2, 2'd0, 2'd1, 2'd0}; end
            10: begin f = 8'b1000_0000; m = {2'd1, 2'd2, 2'd0, 2'd0}; end
            15: f = 8'b0000_0001;
            default: begin f = 8'h00; m = 8'h00; end
        endcase
        return {f, m};
    endfunction

    function automatic logic rbit();
        return ($urandom_range(0, 1) == 1);
    endfunction

    // One clock of stimulus; records what the DUT must present this cycle
    task automatic cyc(input int s, input logic rdy, input bit retires);
        if (aborted) return;
        @(negedge clk);
        if (cyc_idx == 0) opcode = cur_op;
        mem_ready = rdy;
        reset     = (cyc_idx == abort_at);
        if (force_pending) begin
            force dut.instret_q = 32'hFFFF_FFFF;
            m_instret = 32'hFFFF_FFFF;
        end
        #1;
        if (force_pending) begin
            release dut.instret_q;
            force_pending = 1'b0;
        end
        exp_q.push_back('{st: s[3:0], ctl: ctl_of(s, rdy), cnt: m_instret});
        if (reset) begin
            aborted   = 1'b1;
            m_instret = 32'd0;
        end else if (retires) begin
            m_instret = m_instret + 32'd1;
        end
        cyc_idx++;
    endtask

    // Expand one instruction into its cycle sequence
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int abort, input int ntrap);
        aborted  = 1'b0;
        cyc_idx  = 0;
        abort_at = abort;
        cur_op   = op;
        for (int i = 0; i < fw; i++) cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b0);
        cyc(1, rbit(), 1'b0);
        case (op)
            7'b0000011: begin
                cyc(2, rbit(), 1'b0);
                for (int i = 0; i < mw; i++) cyc(3, 1'b0, 1'b0);
                cyc(3, 1'b1, 1'b0);
                cyc(4, rbit(), 1'b1);
            end
            7'b0100011: begin
                cyc(2, rbit(), 1'b0);
                for (int i = 0; i < mw; i++) cyc(5, 1'b0, 1'b0);
                cyc(5, 1'b1, 1'b1);
            end
            7'b0110011: begin cyc(6, rbit(), 1'b0); cyc(7, rbit(), 1'b1); end
            7'b0010011: begin cyc(8, rbit(), 1'b0); cyc(7, rbit(), 1'b1); end
            7'b1100011: cyc(9, rbit(), 1'b1);
`ifdef MAIN_CONTROL_JAL_EN
            7'b1101111: begin cyc(10, rbit(), 1'b0); cyc(7, rbit(), 1'b1); end
`endif
            default: begin
                for (int i = 0; i < ntrap; i++) cyc(15, rbit(), 1'b0);
                if (!aborted) abort_at = cyc_idx;
                cyc(15, rbit(), 1'b0);
            end
        endcase
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] o;
        case ($urandom_range(0, 7))
            0, 1:    o = 7'b0000011;
            2:       o = 7'b0100011;
            3:       o = 7'b0110011;
            4:       o = 7'b0010011;
            5:       o = 7'b1100011;
            6:       o = 7'b1101111;
            default: o = 7'($urandom_range(0, 127));
        endcase
        return o;
    endfunction

    // Monitor: compare the DUT against the oldest expectation every cycle
    initial begin
        exp_t e;
        logic [15:0] act;
        int n = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {pc_write, ir_write, mem_req, mem_we, iord, reg_write, branch,
                       illegal, alusrc_a, alusrc_b, aluop, result_src};
                checks += 3;
                if (state !== e.st) begin
                    errors++;
                    $display("FAIL state[%0d] got %0d want %0d", n, state, e.st);
                end
                if (act !== e.ctl) begin
                    errors++;
                    $display("FAIL ctrl[%0d] st=%0d got %b want %b", n, e.st, act, e.ctl);
                end
                if (instret !== e.cnt) begin
                    errors++;
                    $display("FAIL instret[%0d] got %h want %h", n, instret, e.cnt);
                end
                n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        opcode    = 7'd0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);

        // lw, always ready
        run_instr(7'b0000011, 0, 0, -1, 0);
        // sw, memory stalls three cycles
        run_instr(7'b0100011, 1, 3, -1, 0);
        // illegal opcode sits in TRAP, then reset recovers
        run_instr(7'b0000000, 0, 0, -1, 10);
        // reset while MEMREAD waits on memory
        run_instr(7'b0000011, 0, 0, -1, 0);
        run_instr(7'b0000011, 0, 3, 3, 0);
        // beq and the JAL opcode
        run_instr(7'b1100011, 2, 0, -1, 0);
        run_instr(7'b1101111, 0, 0, -1, 3);
        // count wraps when an add retires at all-ones
        run_instr(7'b0110011, 0, 0, -1, 0);
        force_pending = 1'b1;
        run_instr(7'b0110011, 0, 0, -1, 0);
        run_instr(7'b0010011, 0, 0, -1, 0);

        for (int k = 0; k < 250; k++) begin
            int ab;
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                      ab, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
